// File: rtl/arm_mem_pkg.sv
// Shared types for the MEM-stage data memory: access size, controller state, wait counter width.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data, load extract and extend.
// Purely combinational, zero latency; no flow control of its own.
module mem_lane_align
    import arm_mem_pkg::*;
(
    input  logic [1:0]  lane,
    input  mem_size_t   mem_size,
    input  logic        mem_signed,
    input  logic [31:0] rm_val,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        byte_en = 4'b0000;
        wr_word = rm_val;
        ld_data = rd_word;
        ld_byte = rd_word[8*lane +: 8];
        ld_half = rd_word[16*lane[1] +: 16];
        case (mem_size)
            MEM_BYTE: begin
                byte_en = 4'b0001 << lane;
                wr_word = {4{rm_val[7:0]}};
                ld_data = {{24{mem_signed & ld_byte[7]}}, ld_byte};
            end
            MEM_HALF: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{rm_val[15:0]}};
                ld_data = {{16{mem_signed & ld_half[15]}}, ld_half};
            end
            MEM_WORD: begin
                byte_en = 4'b1111;
            end
            default: begin
                ld_data = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data RAM with byte/half/word access and range/alignment fault detection.
// Each access takes WAIT_CYCLES+1 cycles; mem_freeze holds the pipeline for the first WAIT_CYCLES.
module data_memory_ctrl
    import arm_mem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] alu_res,
    input  logic [31:0] rm_val,
    input  mem_size_t   mem_size,
    input  logic        mem_signed,
    output logic [31:0] data_mem,
    output logic        mem_freeze,
    output logic        mem_fault
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [31:0]     BASE     = 32'(BASE_ADDR);
    localparam logic [31:0]     LIMIT    = 32'(4 * DEPTH);
    localparam logic [WAIT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    mem_state_t        state;
    logic [WAIT_W-1:0] cnt;
    logic [31:0]       ram [DEPTH];

    logic [31:0] offset;
    logic [AW-1:0] idx;
    logic [1:0]  lane;
    logic [31:0] rd_word;
    logic [31:0] wr_word;
    logic [31:0] ld_data;
    logic [3:0]  byte_en;
    logic        req;
    logic        fault;
    logic        start;
    logic        done;

    assign req     = mem_r_en | mem_w_en;
    assign offset  = alu_res - BASE;
    assign idx     = offset[AW+1:2];
    assign lane    = offset[1:0];
    assign rd_word = ram[idx];

    // Faults are judged only on entry; inputs are held stable for the rest of the access.
    always_comb begin
        fault = 1'b0;
        if (!rst && state == IDLE && req) begin
            fault = (alu_res < BASE)
                  || (offset >= LIMIT)
                  || (mem_size == MEM_RSVD)
                  || (mem_size == MEM_HALF && lane[0])
                  || (mem_size == MEM_WORD && lane != 2'b00)
                  || (mem_r_en && mem_w_en);
        end
    end

    assign start = !rst && state == IDLE && req && !fault;
    assign done  = (start && WAIT_CYCLES == 0) || (!rst && state == BUSY && cnt == '0);

    assign mem_freeze = (start && WAIT_CYCLES != 0) || (!rst && state == BUSY && cnt != '0);
    assign mem_fault  = fault;
    assign data_mem   = (done && mem_r_en) ? ld_data : '0;

    mem_lane_align u_align (
        .lane       (lane),
        .mem_size   (mem_size),
        .mem_signed (mem_signed),
        .rm_val     (rm_val),
        .rd_word    (rd_word),
        .byte_en    (byte_en),
        .wr_word    (wr_word),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk) begin
        if (done && mem_w_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    ram[idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && WAIT_CYCLES != 0) begin
                        state <= BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: a WAIT_CYCLES=0 instance (index 0) and a WAIT_CYCLES=2 instance (index 1)
// checked every cycle against a byte-array memory model.
module tb_data_memory_ctrl;
    import arm_mem_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [31:0] LO    = 32'd1024;
    localparam logic [31:0] HI    = 32'd1280;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_en   [2];
    logic        w_en   [2];
    logic        sgn    [2];
    logic [31:0] addr   [2];
    logic [31:0] wdat   [2];
    mem_size_t   sz     [2];
    logic [31:0] data_mem [2];
    logic        freeze [2];
    logic        fault  [2];

    logic [31:0] exp_data   [2];
    logic        exp_freeze [2];
    logic        exp_fault  [2];
    logic [7:0]  mb [2][4*DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]), .alu_res(addr[0]),
        .rm_val(wdat[0]), .mem_size(sz[0]), .mem_signed(sgn[0]), .data_mem(data_mem[0]),
        .mem_freeze(freeze[0]), .mem_fault(fault[0])
    );

    data_memory_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(1024), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]), .alu_res(addr[1]),
        .rm_val(wdat[1]), .mem_size(sz[1]), .mem_signed(sgn[1]), .data_mem(data_mem[1]),
        .mem_freeze(freeze[1]), .mem_fault(fault[1])
    );

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %h expected %h", name, k, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check("data_mem", k, data_mem[k], exp_data[k]);
            check("mem_freeze", k, 32'(freeze[k]), 32'(exp_freeze[k]));
            check("mem_fault", k, 32'(fault[k]), 32'(exp_fault[k]));
        end
    end

    function automatic bit model_fault(input bit r, input bit w, input logic [31:0] a, input logic [1:0] s);
        if (r && w) return 1'b1;
        if (a < LO || a >= HI) return 1'b1;
        if (s == 2'd3) return 1'b1;
        if (s == 2'd1 && a[0]) return 1'b1;
        if (s == 2'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input int k, input logic [31:0] a, input logic [1:0] s, input bit sg);
        int o;
        logic [31:0] v;
        o = int'(a - LO);
        case (s)
            2'd0:    v = sg ? 32'($signed(mb[k][o])) : 32'(mb[k][o]);
            2'd1:    v = sg ? 32'($signed({mb[k][o+1], mb[k][o]})) : 32'({mb[k][o+1], mb[k][o]});
            default: v = {mb[k][o+3], mb[k][o+2], mb[k][o+1], mb[k][o]};
        endcase
        return v;
    endfunction

    task automatic model_store(input int k, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int o;
        int n;
        o = int'(a - LO);
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) mb[k][o+i] = d[8*i +: 8];
    endtask

    task automatic set_idle(input int k);
        r_en[k] = 1'b0;
        w_en[k] = 1'b0;
        exp_data[k] = '0;
        exp_freeze[k] = 1'b0;
        exp_fault[k] = 1'b0;
    endtask

    task automatic idle_all();
        @(posedge clk); #1;
        set_idle(0);
        set_idle(1);
    endtask

    task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] s, input bit sg);
        int wc;
        logic [31:0] ld;
        wc = (k == 0) ? 0 : 2;
        @(posedge clk); #1;
        r_en[k] = r; w_en[k] = w; addr[k] = a; wdat[k] = d; sz[k] = mem_size_t'(s); sgn[k] = sg;
        exp_data[k] = '0; exp_freeze[k] = 1'b0; exp_fault[k] = 1'b0;
        if (!r && !w) begin
            // no request: outputs stay quiet for one cycle
        end else if (model_fault(r, w, a, s)) begin
            exp_fault[k] = 1'b1;
        end else begin
            ld = r ? model_load(k, a, s, sg) : 32'h0;
            for (int c = 0; c <= wc; c++) begin
                if (c > 0) begin
                    @(posedge clk); #1;
                end
                exp_freeze[k] = (c < wc);
                exp_data[k]   = (c == wc) ? ld : 32'h0;
            end
            if (w) model_store(k, a, d, s);
        end
    endtask

    task automatic rand_access(input int k);
        int sel;
        bit r, w;
        logic [1:0] s;
        logic [31:0] a;
        sel = $urandom_range(0, 19);
        r = (sel < 9) || (sel == 18);
        w = (sel >= 9 && sel < 19);
        s = 2'($urandom_range(0, 3));
        if (s == 2'd3 && $urandom_range(0, 3) != 0) s = 2'd2;
        case ($urandom_range(0, 9))
            0: a = LO - 32'($urandom_range(1, 8));
            1: a = HI + 32'($urandom_range(0, 8));
            default: begin
                a = LO + 32'($urandom_range(0, 255));
                if ($urandom_range(0, 4) != 0) begin
                    if (s == 2'd1) a[0] = 1'b0;
                    if (s == 2'd2) a[1:0] = 2'b00;
                end
            end
        endcase
        access(k, r, w, a, $urandom, s, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            set_idle(k);
            addr[k] = LO; wdat[k] = '0; sz[k] = MEM_WORD; sgn[k] = 1'b0;
        end
        // a pending request while reset is held must not show on the outputs
        r_en[1] = 1'b1;
        addr[1] = 32'd1028;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        set_idle(1);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) access(k, 1'b0, 1'b1, LO + 32'(4*i), $urandom, 2'd2, 1'b0);
            idle_all();
        end

        access(1, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 2'd2, 1'b0);
        access(1, 1'b1, 1'b0, 32'd1028, 32'h0, 2'd2, 1'b0);
        @(negedge clk); check("word_roundtrip", 1, data_mem[1], 32'hDEADBEEF);
        access(1, 1'b0, 1'b1, 32'd1029, 32'h000000A5, 2'd0, 1'b0);
        check("model_byte_merge", 1, model_load(1, 32'd1028, 2'd2, 1'b0), 32'hDEADA5EF);
        access(1, 1'b1, 1'b0, 32'd1028, 32'h0, 2'd2, 1'b1);
        @(negedge clk); check("byte_merge", 1, data_mem[1], 32'hDEADA5EF);
        access(1, 1'b1, 1'b0, 32'd1029, 32'h0, 2'd0, 1'b1);
        @(negedge clk); check("ldsb", 1, data_mem[1], 32'hFFFFFFA5);
        access(1, 1'b1, 1'b0, 32'd1029, 32'h0, 2'd0, 1'b0);
        @(negedge clk); check("ldub", 1, data_mem[1], 32'h000000A5);
        check("model_ldsh", 1, model_load(1, 32'd1030, 2'd1, 1'b1), 32'hFFFFDEAD);
        access(1, 1'b1, 1'b0, 32'd1030, 32'h0, 2'd1, 1'b1);
        @(negedge clk); check("ldsh", 1, data_mem[1], 32'hFFFFDEAD);

        access(1, 1'b1, 1'b0, 32'd1029, 32'h0, 2'd1, 1'b0);
        @(negedge clk); check("half_misalign_fault", 1, 32'(fault[1]), 32'd1);
        access(1, 1'b0, 1'b1, 32'd1030, 32'h11111111, 2'd2, 1'b0);
        access(1, 1'b0, 1'b1, 32'd1028, 32'h22222222, 2'd3, 1'b0);
        access(1, 1'b0, 1'b1, 32'd1020, 32'h33333333, 2'd2, 1'b0);
        access(1, 1'b0, 1'b1, 32'd1280, 32'h44444444, 2'd2, 1'b0);
        @(negedge clk); check("above_range_fault", 1, 32'(fault[1]), 32'd1);
        access(1, 1'b1, 1'b1, 32'd1028, 32'h55555555, 2'd2, 1'b0);
        access(1, 1'b1, 1'b0, 32'd1028, 32'h0, 2'd2, 1'b0);
        @(negedge clk); check("faults_leave_ram", 1, data_mem[1], 32'hDEADA5EF);
        access(1, 1'b0, 1'b1, 32'd1276, 32'h13579BDF, 2'd2, 1'b0);
        access(1, 1'b1, 1'b0, 32'd1276, 32'h0, 2'd2, 1'b0);
        @(negedge clk); check("last_word", 1, data_mem[1], 32'h13579BDF);

        // store aborted by reset in its first BUSY cycle must never land
        access(1, 1'b0, 1'b1, 32'd1032, 32'h0BADF00D, 2'd2, 1'b0);
        @(posedge clk); #1;
        r_en[1] = 1'b0; w_en[1] = 1'b1; addr[1] = 32'd1032; wdat[1] = 32'h12345678; sz[1] = MEM_WORD;
        exp_freeze[1] = 1'b1; exp_data[1] = '0; exp_fault[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_freeze[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle(1);
        access(1, 1'b1, 1'b0, 32'd1032, 32'h0, 2'd2, 1'b0);
        @(negedge clk); check("reset_abort", 1, data_mem[1], 32'h0BADF00D);
        idle_all();

        access(0, 1'b0, 1'b1, 32'd1100, 32'hCAFEF00D, 2'd2, 1'b0);
        access(0, 1'b1, 1'b0, 32'd1100, 32'h0, 2'd2, 1'b0);
        @(negedge clk); check("w0_word", 0, data_mem[0], 32'hCAFEF00D);
        check("w0_no_freeze", 0, 32'(freeze[0]), 32'd0);
        access(0, 1'b1, 1'b0, 32'd1103, 32'h0, 2'd0, 1'b1);
        @(negedge clk); check("w0_ldsb", 0, data_mem[0], 32'hFFFFFFCA);
        idle_all();

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 250; i++) rand_access(k);
            idle_all();
        end
        idle_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
